// File: rtl/qpsk_pkg.sv
// Shared constants and types for the QPSK receive controller.
package qpsk_pkg;

    // Bits carried by one demodulated QPSK symbol.
    localparam int SYMBOL_W = 2;

    // Default 16-bit sync word: 8 symbols, first symbol is bits [15:14].
    localparam logic [15:0] DEFAULT_SYNC = 16'hA5C3;

    // Receive sequencing states.
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/qpsk_rx_fifo.sv
// First-word-fall-through sample FIFO. The head entry is presented straight
// from the storage registers, so o_data stays stable until it is popped.
// Pops on an empty FIFO are ignored. Pushes on a full FIFO are dropped unless
// a pop happens in the same cycle.
module qpsk_rx_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign w_pop_ok  = i_pop & (r_count != '0);
    assign w_push_ok = i_push & ((r_count != CW'(DEPTH)) | w_pop_ok);

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, circular pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/qpsk_rx_controller.sv
// QPSK receive sequencer: registers accepted I/Q into the external demodulator,
// captures its symbol one cycle later, hunts for the sync word, then packs
// symbols MSB-first into audio samples and emits one frame through a FIFO.
//
//   state   | meaning
//   HUNT    | shifting symbols through sync_sr looking for SYNC_PATTERN
//   COLLECT | locked; assembling FRAME_SAMPLES samples, then back to HUNT
module qpsk_rx_controller
    import qpsk_pkg::*;
#(
    parameter int          SAMPLE_W      = 16,
    parameter logic [15:0] SYNC_PATTERN  = DEFAULT_SYNC,
    parameter int          FRAME_SAMPLES = 64,
    parameter int          OUT_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_i,
    input  logic [15:0]         in_q,
    output logic [15:0]         demod_i,
    output logic [15:0]         demod_q,
    input  logic [SYMBOL_W-1:0] demod_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_sample,
    output logic                out_last,
    output logic                locked
);

    localparam int SPS = SAMPLE_W / SYMBOL_W;
    localparam int SCW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int FCW = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
    localparam int CW  = $clog2(OUT_DEPTH + 1);

    state_t        r_state;
    logic          r_sym_v;
    logic [15:0]   r_demod_i;
    logic [15:0]   r_demod_q;
    logic [15:0]   r_sync_sr;
    logic [3:0]    r_hunt_cnt;
    logic [SCW-1:0] r_sym_cnt;
    logic [FCW-1:0] r_sample_cnt;

    logic                w_accept;
    logic [15:0]         w_sync_next;
    logic [3:0]          w_hunt_next;
    logic                w_match;
    logic                w_collect_sym;
    logic                w_sym_last;
    logic                w_frame_last;
    logic                w_push;
    logic [SAMPLE_W-1:0] w_asm_next;
    logic [CW-1:0]       w_fifo_count;

    // One free slot is kept so the sample already in flight always fits.
    assign in_ready = (w_fifo_count < CW'(OUT_DEPTH - 1)) & ~reset;
    assign w_accept = in_valid & in_ready;

    assign demod_i = r_demod_i;
    assign demod_q = r_demod_q;
    assign locked  = (r_state == COLLECT);

    assign w_sync_next   = {r_sync_sr[13:0], demod_data};
    assign w_hunt_next   = (r_hunt_cnt == 4'd8) ? 4'd8 : r_hunt_cnt + 4'd1;
    assign w_match       = (w_sync_next == SYNC_PATTERN) && (w_hunt_next == 4'd8);
    assign w_collect_sym = r_sym_v && (r_state == COLLECT);
    assign w_sym_last    = (r_sym_cnt == SCW'(SPS - 1));
    assign w_frame_last  = (r_sample_cnt == FCW'(FRAME_SAMPLES - 1));
    assign w_push        = w_collect_sym && w_sym_last;

    // The assembly register holds only the earlier symbols of a sample; the
    // final symbol is appended combinationally at push time.
    generate
        if (SAMPLE_W > SYMBOL_W) begin : g_asm
            logic [SAMPLE_W-SYMBOL_W-1:0] r_asm_sr;
            assign w_asm_next = {r_asm_sr, demod_data};

            // Shift each captured symbol in while collecting.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_asm_sr <= '0;
                end else if (w_collect_sym) begin
                    r_asm_sr <= w_asm_next[SAMPLE_W-SYMBOL_W-1:0];
                end
            end
        end else begin : g_asm_single
            assign w_asm_next = demod_data;
        end
    endgenerate

    // Register accepted I/Q toward the demodulator and flag the symbol for capture next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_demod_i <= '0;
            r_demod_q <= '0;
            r_sym_v   <= 1'b0;
        end else begin
            r_sym_v <= w_accept;
            if (w_accept) begin
                r_demod_i <= in_i;
                r_demod_q <= in_q;
            end
        end
    end

    // Hunt/collect sequencing on each captured symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= HUNT;
            r_sync_sr    <= '0;
            r_hunt_cnt   <= '0;
            r_sym_cnt    <= '0;
            r_sample_cnt <= '0;
        end else if (r_sym_v) begin
            case (r_state)
                HUNT: begin
                    r_sync_sr  <= w_sync_next;
                    r_hunt_cnt <= w_hunt_next;
                    if (w_match) begin
                        r_state      <= COLLECT;
                        r_sym_cnt    <= '0;
                        r_sample_cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (w_sym_last) begin
                        r_sym_cnt    <= '0;
                        r_sample_cnt <= r_sample_cnt + 1'b1;
                        if (w_frame_last) begin
                            r_state      <= HUNT;
                            r_sync_sr    <= '0;
                            r_hunt_cnt   <= '0;
                            r_sample_cnt <= '0;
                        end
                    end else begin
                        r_sym_cnt <= r_sym_cnt + 1'b1;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    qpsk_rx_fifo #(
        .WIDTH (SAMPLE_W + 1),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({w_frame_last, w_asm_next}),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_data  ({out_last, out_sample}),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_qpsk_rx_controller.sv
// Bench for qpsk_rx_controller with a sign-slicing demodulator stub.
module tb_qpsk_rx_controller;

    localparam int          SAMPLE_W = 16;
    localparam int          FS       = 2;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] SYNC     = 16'hA5C3;
    localparam int          TIMEOUT  = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_i;
    logic [15:0] in_q;
    logic [15:0] demod_i;
    logic [15:0] demod_q;
    logic [1:0]  demod_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sample;
    logic        out_last;
    logic        locked;

    assign demod_data = {demod_i[15], demod_q[15]};

    qpsk_rx_controller #(
        .SAMPLE_W      (SAMPLE_W),
        .SYNC_PATTERN  (SYNC),
        .FRAME_SAMPLES (FS),
        .OUT_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_i       (in_i),
        .in_q       (in_q),
        .demod_i    (demod_i),
        .demod_q    (demod_q),
        .demod_data (demod_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_last   (out_last),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: expected FIFO contents, hunt history, frame progress.
    logic [16:0] m_q[$];
    logic [16:0] log_q[$];
    logic [1:0]  hist[$];
    bit          m_locked = 0;
    logic [15:0] m_word;
    int          m_nsym, m_nsamp;
    bit          saw_valid, saw_locked;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic void model_reset();
        m_q.delete();
        hist.delete();
        m_locked = 0;
        m_word   = '0;
        m_nsym   = 0;
        m_nsamp  = 0;
    endfunction

    // Consume one symbol: sliding 8-symbol window while hunting, sample packing while locked.
    function automatic void model_sym(input logic [1:0] s);
        logic [15:0] p;
        logic [1:0]  ps;
        bit          ok;
        bit          lst;
        if (!m_locked) begin
            hist.push_back(s);
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() == 8) begin
                ok = 1;
                p  = SYNC;
                for (int k = 0; k < 8; k++) begin
                    ps = p[15:14];
                    p  = p << 2;
                    if (hist[k] != ps) ok = 0;
                end
                if (ok) begin
                    m_locked = 1;
                    m_word   = '0;
                    m_nsym   = 0;
                    m_nsamp  = 0;
                end
            end
        end else begin
            m_word = {m_word[13:0], s};
            m_nsym++;
            if (m_nsym == SAMPLE_W / 2) begin
                lst = (m_nsamp == FS - 1);
                m_q.push_back({lst, m_word});
                m_nsamp++;
                m_nsym = 0;
                if (lst) begin
                    m_locked = 0;
                    hist.delete();
                end
            end
        end
    endfunction

    // Compare process: handshakes observed before each edge, state checked just after it.
    initial begin
        bit          acc, pop, pend;
        logic [1:0]  psym, asym;
        pend = 0;
        psym = '0;
        forever begin
            @(negedge clk);
            #2;
            acc  = in_valid & in_ready & ~reset;
            asym = {in_i[15], in_q[15]};
            pop  = out_valid & out_ready & ~reset;
            if (pop) begin
                if (m_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no sample at %0t",
                             {out_last, out_sample}, $time);
                end else begin
                    check("pop_data", {15'd0, out_last, out_sample}, {15'd0, m_q[0]});
                end
                log_q.push_back({out_last, out_sample});
            end
            @(posedge clk);
            #1;
            if (reset) begin
                model_reset();
                pend = 0;
                check("rst_out_valid", out_valid, 0);
                check("rst_locked", locked, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_demod_i", demod_i, 0);
                check("rst_demod_q", demod_q, 0);
                check("rst_out_sample", {out_last, out_sample}, 0);
            end else begin
                if (pop && m_q.size() > 0) void'(m_q.pop_front());
                if (pend) model_sym(psym);
                pend = acc;
                psym = asym;
                if (m_q.size() > DEPTH) begin
                    n_checks++;
                    $display("FAIL fifo_overflow: got %0d entries required at most %0d", m_q.size(), DEPTH);
                end
                check("out_valid", out_valid, (m_q.size() != 0));
                check("in_ready", in_ready, (m_q.size() < DEPTH - 1));
                check("locked", locked, m_locked);
                if (m_q.size() > 0)
                    check("out_head", {15'd0, out_last, out_sample}, {15'd0, m_q[0]});
                saw_valid  |= out_valid;
                saw_locked |= locked;
            end
        end
    end

    task automatic send_sym(input logic [1:0] s);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_i = {s[1], 15'($urandom_range(0, 32767))};
        in_q = {s[0], 15'($urandom_range(0, 32767))};
        t = 0;
        #2;
        while (!in_ready && t < TIMEOUT) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= TIMEOUT) fail_now("send_sym");
    endtask

    task automatic send_word(input logic [15:0] w);
        logic [15:0] v;
        v = w;
        for (int k = 0; k < 8; k++) begin
            send_sym(v[15:14]);
            v = v << 2;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while (log_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        #3;
        if (log_q.size() < n) fail_now("wait_log");
    endtask

    logic [15:0] t4_vals [8] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h5555,
                                 16'hA5C3, 16'h3C3C, 16'h7E81, 16'h0000};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_i      = '0;
        in_q      = '0;
        out_ready = 1'b1;

        // 1: reset held three cycles, then released
        repeat (3) @(negedge clk);
        #2;
        check("t1_out_valid", out_valid, 0);
        check("t1_locked", locked, 0);
        check("t1_demod_i", demod_i, 0);
        check("t1_demod_q", demod_q, 0);
        check("t1_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t1_in_ready_release", in_ready, 1);

        // 2: two junk symbols, then the sync word
        send_sym(2'b11);
        send_sym(2'b01);
        send_word(SYNC);
        check("t2_not_locked_yet", locked, 0);
        idle(1);
        @(posedge clk);
        #1;
        check("t2_locked", locked, 1);

        // 3: one frame of two samples with the sink always ready
        log_q.delete();
        send_word(16'h1234);
        send_word(16'hBEEF);
        idle(2);
        wait_log(2);
        check("t3_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("t3_s0", log_q[0], {1'b0, 16'h1234});
            check("t3_s1", log_q[1], {1'b1, 16'hBEEF});
        end
        check("t3_unlocked", locked, 0);

        // 4: four frames against a stalled sink, released later
        log_q.delete();
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    send_word(SYNC);
                    send_word(t4_vals[2*f]);
                    send_word(t4_vals[2*f+1]);
                end
                idle(2);
            end
            begin
                repeat (120) @(negedge clk);
                #2;
                check("t4_stall_in_ready", in_ready, 0);
                check("t4_stall_valid", out_valid, 1);
                check("t4_stall_head", out_sample, t4_vals[0]);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_log(8);
        check("t4_count", log_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < log_q.size())
                check("t4_order", log_q[k], {(k % 2 == 1), t4_vals[k]});
        end

        // 5: near-miss words must never lock
        saw_valid  = 0;
        saw_locked = 0;
        send_word(16'hA5C2);
        send_word(16'h5A3C);
        idle(4);
        check("t5_saw_locked", saw_locked, 0);
        check("t5_saw_valid", saw_valid, 0);

        // 6: reset part-way through a sample, then a clean frame
        log_q.delete();
        send_word(SYNC);
        send_sym(2'b10);
        send_sym(2'b01);
        send_sym(2'b11);
        do_reset(2);
        #1;
        check("t6_valid_after_rst", out_valid, 0);
        check("t6_locked_after_rst", locked, 0);
        send_word(SYNC);
        send_word(16'hCAFE);
        send_word(16'h0F0F);
        idle(2);
        wait_log(2);
        check("t6_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("t6_s0", log_q[0], {1'b0, 16'hCAFE});
            check("t6_s1", log_q[1], {1'b1, 16'h0F0F});
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
